// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: hunts for a sync pattern, then unpacks MSB-first words,
// each followed by an even-parity bit, into a valid/ready output register.
module serial_frame_deserializer #(
    parameter int                DATA_W          = 8,
    parameter int                SYNC_W          = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN    = 8'hA5,
    parameter int                WORDS_PER_FRAME = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              word_ready,
    input  logic              clr_overflow,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    output logic              parity_err,
    output logic              overflow,
    output logic              locked
);

    localparam int BIT_CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WORD_CNT_W = $clog2(WORDS_PER_FRAME + 1);

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        PARITY
    } state_t;

    state_t                state, state_next;
    logic [SYNC_W-1:0]     sync_sr, sync_next;
    logic [DATA_W-1:0]     data_sr, data_next;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_next;
    logic [WORD_CNT_W-1:0] word_cnt, word_cnt_next;
    logic                  good_word, bad_word, slot_free;

    assign slot_free = !word_valid || word_ready;
    assign locked    = (state == DATA) || (state == PARITY);

    // NOTE: every signal driven here gets a default before any branch, so no latches are inferred.
    always_comb begin
        state_next    = state;
        sync_next     = sync_sr;
        data_next     = data_sr;
        bit_cnt_next  = bit_cnt;
        word_cnt_next = word_cnt;
        good_word     = 1'b0;
        bad_word      = 1'b0;
        if (bit_valid) begin
            case (state)
                HUNT: begin
                    sync_next = {sync_sr[SYNC_W-2:0], bit_in};
                    if (sync_next == SYNC_PATTERN) begin
                        state_next    = DATA;
                        bit_cnt_next  = '0;
                        word_cnt_next = '0;
                    end
                end
                DATA: begin
                    data_next = {data_sr[DATA_W-2:0], bit_in};
                    if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
                        state_next   = PARITY;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (^{data_sr, bit_in}) begin
                        // Bad parity means lock is lost; resynchronise from scratch.
                        bad_word   = 1'b1;
                        state_next = HUNT;
                        sync_next  = '0;
                    end else begin
                        good_word = 1'b1;
                        if (word_cnt == WORD_CNT_W'(WORDS_PER_FRAME - 1)) begin
                            state_next = HUNT;
                            sync_next  = '0;
                        end else begin
                            word_cnt_next = word_cnt + 1'b1;
                            state_next    = DATA;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                    sync_next  = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            sync_sr    <= '0;
            data_sr    <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            sync_sr    <= sync_next;
            data_sr    <= data_next;
            bit_cnt    <= bit_cnt_next;
            word_cnt   <= word_cnt_next;
            parity_err <= bad_word;

            if (good_word && slot_free) begin
                word_out   <= data_sr;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            // A new drop wins over a clear arriving on the same edge.
            if (good_word && !slot_free) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
